// File: rtl/seq_sched_pkg.sv
// Shared types, width helpers and default parameters for the sequence-detector
// scheduler and its round-robin arbiter.
package seq_sched_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int FRAME_W_DEF = 16;
    localparam int DET_LAT_DEF = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } sched_state_e;

    // Bits needed to index n items; never less than one bit.
    function automatic int idx_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

    // Bits needed to hold a count in 0..n.
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_detect_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after the
// pointer, wrapping, returned as a one-hot grant plus its index.
import seq_sched_pkg::*;

module rr_arbiter #(
    parameter int N  = NUM_REQ_DEF,
    parameter int IW = idx_width(NUM_REQ_DEF)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] id_o,
    output logic          valid_o
);

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int i);
        int s;
        s = int'(p) + i;
        if (s >= N) begin
            s = s - N;
        end else begin
            s = s;
        end
        return IW'(s);
    endfunction

    // Scan from the pointer; the first hit wins and masks later ones.
    always_comb begin
        grant_o = '0;
        id_o    = '0;
        valid_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!valid_o && req_i[wrap_add(ptr_i, i)]) begin
                valid_o                    = 1'b1;
                grant_o[wrap_add(ptr_i, i)] = 1'b1;
                id_o                       = wrap_add(ptr_i, i);
            end else begin
                valid_o = valid_o;
            end
        end
    end

endmodule

// File: rtl/seq_detect_scheduler.sv
// Shares one serial sequence detector among NUM_REQ requesters, round-robin.
// Optional macro SEQ_SCHED_FIRST_POS_EN adds the first_pos output.
import seq_sched_pkg::*;

module seq_detect_scheduler #(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int DET_LAT = DET_LAT_DEF
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_REQ-1:0]                     req,
    input  logic [NUM_REQ*FRAME_W-1:0]             frame,
    output logic [NUM_REQ-1:0]                     ack,
    output logic                                   det_x,
    output logic                                   det_reset,
    input  logic                                   det_z,
    output logic                                   done,
    output logic [idx_width(NUM_REQ)-1:0]          done_id,
    output logic [count_width(FRAME_W)-1:0]        match_cnt,
`ifdef SEQ_SCHED_FIRST_POS_EN
    output logic [idx_width(FRAME_W)-1:0]          first_pos,
`endif
    output logic                                   busy
);

    localparam int IW = idx_width(NUM_REQ);
    localparam int CW = count_width(FRAME_W);
    localparam int PW = idx_width(FRAME_W);

    sched_state_e        state_q;
    logic [IW-1:0]       ptr_q;
    logic [IW-1:0]       id_q;
    logic [FRAME_W-1:0]  shreg_q;
    logic [PW-1:0]       bit_q;
    logic [1:0]          drain_q;
    logic [CW-1:0]       cnt_q;
    logic [CW-1:0]       cnt_d;
    logic [NUM_REQ-1:0]  ack_q;
    logic                det_x_q;
    logic                det_reset_q;
    logic                done_q;
    logic [IW-1:0]       done_id_q;
    logic [CW-1:0]       match_cnt_q;
    logic                busy_q;

    logic [NUM_REQ-1:0]  arb_grant_s;
    logic [IW-1:0]       arb_id_s;
    logic                arb_valid_s;
    logic                start_s;
    logic                shift_flag_s;
    logic                win_s;
    logic                last_bit_s;
    logic                to_done_s;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_arb (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant_s),
        .id_o    (arb_id_s),
        .valid_o (arb_valid_s)
    );

    assign start_s      = (state_q == ST_IDLE) && arb_valid_s;
    assign shift_flag_s = (state_q == ST_SHIFT);
    assign last_bit_s   = (bit_q == PW'(FRAME_W - 1));
    assign to_done_s    = (shift_flag_s && last_bit_s && (DET_LAT == 0)) ||
                          ((state_q == ST_DRAIN) && (drain_q == 2'(DET_LAT - 1)));

    // det_z is only meaningful DET_LAT cycles after the matching SHIFT cycle.
    generate
        if (DET_LAT == 0) begin : g_no_lat
            assign win_s = shift_flag_s;
        end else begin : g_lat
            logic [DET_LAT-1:0] win_pipe_q;
            // Delay line of the SHIFT flag that defines the count window.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    win_pipe_q <= '0;
                end else begin
                    win_pipe_q[0] <= shift_flag_s;
                    for (int i = 1; i < DET_LAT; i++) begin
                        win_pipe_q[i] <= win_pipe_q[i-1];
                    end
                end
            end
            assign win_s = win_pipe_q[DET_LAT-1];
        end
    endgenerate

    // Saturating match counter next value.
    always_comb begin
        if (win_s && det_z && (cnt_q != CW'(FRAME_W))) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Scheduler FSM with all externally visible outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            shreg_q     <= '0;
            bit_q       <= '0;
            drain_q     <= 2'd0;
            cnt_q       <= '0;
            ack_q       <= '0;
            det_x_q     <= 1'b0;
            det_reset_q <= 1'b1;
            done_q      <= 1'b0;
            done_id_q   <= '0;
            match_cnt_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            ack_q  <= '0;
            done_q <= 1'b0;
            cnt_q  <= cnt_d;
            case (state_q)
                ST_IDLE: begin
                    det_reset_q <= 1'b1;
                    det_x_q     <= 1'b0;
                    if (arb_valid_s) begin
                        state_q <= ST_CLR;
                        id_q    <= arb_id_s;
                        shreg_q <= frame[int'(arb_id_s)*FRAME_W +: FRAME_W];
                        ack_q   <= arb_grant_s;
                        ptr_q   <= (arb_id_s == IW'(NUM_REQ - 1)) ? '0 : arb_id_s + IW'(1);
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ST_CLR: begin
                    state_q     <= ST_SHIFT;
                    det_reset_q <= 1'b0;
                    det_x_q     <= shreg_q[FRAME_W-1];
                    shreg_q     <= {shreg_q[FRAME_W-2:0], 1'b0};
                    bit_q       <= '0;
                end
                ST_SHIFT: begin
                    if (last_bit_s) begin
                        det_x_q <= 1'b0;
                        drain_q <= 2'd0;
                        state_q <= (DET_LAT == 0) ? ST_DONE : ST_DRAIN;
                    end else begin
                        bit_q   <= bit_q + PW'(1);
                        det_x_q <= shreg_q[FRAME_W-1];
                        shreg_q <= {shreg_q[FRAME_W-2:0], 1'b0};
                    end
                end
                ST_DRAIN: begin
                    det_x_q <= 1'b0;
                    if (to_done_s) begin
                        state_q <= ST_DONE;
                    end else begin
                        drain_q <= drain_q + 2'd1;
                    end
                end
                ST_DONE: begin
                    state_q     <= ST_IDLE;
                    busy_q      <= 1'b0;
                    det_reset_q <= 1'b1;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    busy_q      <= 1'b0;
                    det_reset_q <= 1'b1;
                    det_x_q     <= 1'b0;
                end
            endcase
            // The final window sample lands on the same edge that enters DONE.
            if (to_done_s) begin
                done_q      <= 1'b1;
                done_id_q   <= id_q;
                match_cnt_q <= cnt_d;
            end else begin
                done_q <= 1'b0;
            end
        end
    end

`ifdef SEQ_SCHED_FIRST_POS_EN
    logic [PW-1:0] samp_idx_q;
    logic [PW-1:0] first_q;
    logic [PW-1:0] first_d;
    logic [PW-1:0] first_pos_q;

    // Index of the first window sample that saw a match; stays 0 otherwise.
    always_comb begin
        if (win_s && det_z && (cnt_q == '0)) begin
            first_d = samp_idx_q;
        end else begin
            first_d = first_q;
        end
    end

    // Sample index tracking and first-match capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            samp_idx_q  <= '0;
            first_q     <= '0;
            first_pos_q <= '0;
        end else if (start_s) begin
            samp_idx_q <= '0;
            first_q    <= '0;
        end else begin
            first_q <= first_d;
            if (win_s) begin
                samp_idx_q <= samp_idx_q + PW'(1);
            end else begin
                samp_idx_q <= samp_idx_q;
            end
            if (to_done_s) begin
                first_pos_q <= first_d;
            end else begin
                first_pos_q <= first_pos_q;
            end
        end
    end

    assign first_pos = first_pos_q;
`endif

    assign ack       = ack_q;
    assign det_x     = det_x_q;
    assign det_reset = det_reset_q;
    assign done      = done_q;
    assign done_id   = done_id_q;
    assign match_cnt = match_cnt_q;
    assign busy      = busy_q;

endmodule
